// File: rtl/sdram_test_master.sv
// Pattern write/read-verify client for the SDRAM controller request/acknowledge port.
// Optional per-transaction watchdog is compiled in with `define SDRAM_TEST_TIMEOUT_EN.
module sdram_test_master #(
  parameter int                    ADDR_WIDTH     = 24,
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_FIRST     = 0,
  parameter int                    ADDR_LAST      = 1023,
  parameter logic [DATA_WIDTH-1:0] SEED           = 'hA5C3,
  parameter int                    TIMEOUT_CYCLES = 2047
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pat_inv,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic                  sdram_rh_wl,
  output logic [DATA_WIDTH-1:0] sdram_data_w,
  input  logic [DATA_WIDTH-1:0] sdram_data_r,
  input  logic                  sdram_data_r_en
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_HOLD = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] A_FIRST = ADDR_WIDTH'(ADDR_FIRST);
  localparam logic [ADDR_WIDTH-1:0] A_LAST  = ADDR_WIDTH'(ADDR_LAST);

  logic [2:0]            r_state;
  logic                  r_busy, r_done, r_pass, r_timeout, r_req, r_rh_wl, r_inv;
  logic [15:0]           r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_addr, r_first_addr;
  logic [DATA_WIDTH-1:0] r_data_w, r_first_data;

  logic                  w_last, w_mismatch, w_tmo_fire;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [15:0]           w_err_next;

  // Address bits above DATA_WIDTH are dropped by the cast.
  function automatic logic [DATA_WIDTH-1:0] f_pat(input logic [ADDR_WIDTH-1:0] a, input logic inv);
    logic [DATA_WIDTH-1:0] v;
    v = DATA_WIDTH'(a) ^ SEED;
    return inv ? ~v : v;
  endfunction

  assign w_last     = (r_addr == A_LAST);
  assign w_addr_inc = r_addr + ADDR_WIDTH'(1);
  assign w_mismatch = (r_state == S_RD_WAIT) && sdram_data_r_en && (sdram_data_r != f_pat(r_addr, r_inv));
  assign w_err_next = (w_mismatch && (r_err_cnt != 16'hFFFF)) ? r_err_cnt + 16'd1 : r_err_cnt;

`ifdef SDRAM_TEST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          w_tmo_enter, w_tmo_active;

  assign w_tmo_enter  = ((r_state == S_IDLE) && start) || (r_state == S_WR_HOLD) ||
                        ((r_state == S_RD_WAIT) && sdram_data_r_en && !w_last);
  assign w_tmo_active = (r_state == S_WR_REQ) || (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
  assign w_tmo_fire   = w_tmo_active && (r_tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_tmo_cnt <= '0;
    else if (w_tmo_enter)  r_tmo_cnt <= '0;
    else if (w_tmo_active) r_tmo_cnt <= r_tmo_cnt + TW'(1);
  end
`else
  // Watchdog compiled out: constant-false for any legal TIMEOUT_CYCLES.
  assign w_tmo_fire = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
      r_req        <= 1'b0;
      r_rh_wl      <= 1'b0;
      r_inv        <= 1'b0;
      r_err_cnt    <= '0;
      r_addr       <= '0;
      r_first_addr <= '0;
      r_data_w     <= '0;
      r_first_data <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_WR_REQ;
            r_busy       <= 1'b1;
            r_req        <= 1'b1;
            r_rh_wl      <= 1'b0;
            r_inv        <= pat_inv;
            r_addr       <= A_FIRST;
            r_data_w     <= f_pat(A_FIRST, pat_inv);
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_data <= '0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
          end
        end
        S_WR_REQ, S_RD_REQ: begin
          if (sdram_ack) begin
            r_req   <= 1'b0;
            r_state <= (r_state == S_WR_REQ) ? S_WR_HOLD : S_RD_WAIT;
          end else if (w_tmo_fire) begin
            r_timeout <= 1'b1;
            r_req     <= 1'b0;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_pass    <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_WR_HOLD: begin
          r_req <= 1'b1;
          if (w_last) begin
            r_addr  <= A_FIRST;
            r_rh_wl <= 1'b1;
            r_state <= S_RD_REQ;
          end else begin
            r_addr   <= w_addr_inc;
            r_data_w <= f_pat(w_addr_inc, r_inv);
            r_state  <= S_WR_REQ;
          end
        end
        S_RD_WAIT: begin
          if (sdram_data_r_en) begin
            r_err_cnt <= w_err_next;
            // Saturation keeps err_cnt nonzero, so zero still means "no mismatch yet".
            if (w_mismatch && (r_err_cnt == 16'd0)) begin
              r_first_addr <= r_addr;
              r_first_data <= sdram_data_r;
            end
            if (w_last) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_pass  <= (w_err_next == 16'd0);
              r_state <= S_DONE;
            end else begin
              r_addr  <= w_addr_inc;
              r_req   <= 1'b1;
              r_state <= S_RD_REQ;
            end
          end else if (w_tmo_fire) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_pass    <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_addr;
  assign first_err_data = r_first_data;
  assign sdram_req      = r_req;
  assign sdram_addr     = r_addr;
  assign sdram_rh_wl    = r_rh_wl;
  assign sdram_data_w   = r_data_w;
endmodule

// File: tb/tb_sdram_test_master.sv
// Directed bench for sdram_test_master over a 4-word window with a reactive SDRAM model.
module tb_sdram_test_master;
  localparam int AW = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, start, pat_inv;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr, sdram_addr;
  logic [DW-1:0] first_err_data, sdram_data_w, sdram_data_r;
  logic          sdram_req, sdram_ack, sdram_rh_wl, sdram_data_r_en;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_plain [4] = '{16'hA5C3, 16'hA5C2, 16'hA5C1, 16'hA5C0};
  logic [DW-1:0] exp_inv   [4] = '{16'h5A3C, 16'h5A3D, 16'h5A3E, 16'h5A3F};

  // Model state
  logic [DW-1:0] mem [4];
  logic [DW-1:0] wr_log [$];
  int            wr_cnt [4];
  bit            stall_en = 0, never_ack = 0, corrupt_en = 0;
  int            wait_cnt;
  logic          rd_pend;
  logic [AW-1:0] rd_addr;

  always #5 clk = ~clk;

  sdram_test_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_FIRST(0), .ADDR_LAST(3),
    .SEED(16'hA5C3), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pat_inv(pat_inv),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
    .sdram_rh_wl(sdram_rh_wl), .sdram_data_w(sdram_data_w),
    .sdram_data_r(sdram_data_r), .sdram_data_r_en(sdram_data_r_en)
  );

  // Ideal controller: ack one cycle after req is seen, read data one cycle after ack.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sdram_ack       <= 1'b0;
      sdram_data_r_en <= 1'b0;
      sdram_data_r    <= '0;
      wait_cnt        <= 0;
      rd_pend         <= 1'b0;
      rd_addr         <= '0;
    end else begin
      sdram_ack       <= 1'b0;
      sdram_data_r_en <= 1'b0;
      if (rd_pend) begin
        sdram_data_r_en <= 1'b1;
        sdram_data_r    <= (corrupt_en && rd_addr == 24'd2) ? 16'h0000 : mem[rd_addr[1:0]];
        rd_pend         <= 1'b0;
        $display("txn read  addr=%0d data=%h", rd_addr, (corrupt_en && rd_addr == 24'd2) ? 16'h0000 : mem[rd_addr[1:0]]);
      end
      if (sdram_req && !sdram_ack && !never_ack) begin
        if (stall_en && !sdram_rh_wl && sdram_addr == 24'd2 && wait_cnt < 10) begin
          wait_cnt <= wait_cnt + 1;
        end else begin
          sdram_ack <= 1'b1;
          wait_cnt  <= 0;
          if (sdram_rh_wl) begin
            rd_pend <= 1'b1;
            rd_addr <= sdram_addr;
          end else begin
            mem[sdram_addr[1:0]] <= sdram_data_w;
            wr_log.push_back(sdram_data_w);
            wr_cnt[sdram_addr[1:0]] = wr_cnt[sdram_addr[1:0]] + 1;
            $display("txn write addr=%0d data=%h", sdram_addr, sdram_data_w);
          end
        end
      end
    end
  end

  task automatic clear_log;
    wr_log.delete();
    for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
  endtask

  task automatic pulse_start(input logic inv);
    @(negedge clk);
    start = 1'b1; pat_inv = inv;
    @(negedge clk);
    start = 1'b0; pat_inv = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output bit prev_rd_en);
    seen = 0; prev_rd_en = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      prev_rd_en = sdram_data_r_en;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; pat_inv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({sdram_req, sdram_rh_wl, busy, done, pass, timeout} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {sdram_req, sdram_rh_wl, busy, done, pass, timeout}); end
    n_checks++; if (err_cnt !== 16'h0 || first_err_addr !== '0 || first_err_data !== '0) begin n_fail++; $display("FAIL reset_err: got cnt=%h addr=%h data=%h want 0", err_cnt, first_err_addr, first_err_data); end
    n_checks++; if (sdram_addr !== '0 || sdram_data_w !== '0) begin n_fail++; $display("FAIL reset_bus: got addr=%h data=%h want 0", sdram_addr, sdram_data_w); end
    reset = 1'b0;
  endtask

  task automatic check_log(input string name, input logic [DW-1:0] e0, e1, e2, e3);
    logic [DW-1:0] exp_v [4];
    logic [DW-1:0] got;
    exp_v = '{e0, e1, e2, e3};
    n_checks++; if (wr_log.size() != 4) begin n_fail++; $display("FAIL %s_wr_count: got %0d want 4", name, wr_log.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < wr_log.size()) ? wr_log[i] : 'x;
      n_checks++; if (got !== exp_v[i]) begin n_fail++; $display("FAIL %s_wdata[%0d]: got %h want %h", name, i, got, exp_v[i]); end
    end
  endtask

  task automatic test_basic;
    bit seen, prev;
    clear_log();
    pulse_start(1'b0);
    n_checks++; if (busy !== 1'b1 || sdram_req !== 1'b1) begin n_fail++; $display("FAIL start_latency: got busy=%b req=%b want 1 1", busy, sdram_req); end
    n_checks++; if (sdram_addr !== 24'd0 || sdram_data_w !== 16'hA5C3 || sdram_rh_wl !== 1'b0) begin n_fail++; $display("FAIL first_req: got addr=%h data=%h rw=%b want 0 a5c3 0", sdram_addr, sdram_data_w, sdram_rh_wl); end
    wait_done(seen, prev);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL basic_done: got no done want done within 2000 cycles"); end
    n_checks++; if (prev !== 1'b1) begin n_fail++; $display("FAIL basic_done_timing: got prev data_r_en=%b want 1", prev); end
    n_checks++; if (busy !== 1'b0 || pass !== 1'b1 || err_cnt !== 16'd0 || timeout !== 1'b0) begin n_fail++; $display("FAIL basic_result: got busy=%b pass=%b err=%0d tmo=%b want 0 1 0 0", busy, pass, err_cnt, timeout); end
    check_log("basic", exp_plain[0], exp_plain[1], exp_plain[2], exp_plain[3]);
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || pass !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got done=%b pass=%b want 0 1", done, pass); end
  endtask

  task automatic test_pat_inv;
    bit seen, prev;
    clear_log();
    pulse_start(1'b1);
    wait_done(seen, prev);
    n_checks++; if (!seen || pass !== 1'b1 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL inv_result: got done=%b pass=%b err=%0d want 1 1 0", seen, pass, err_cnt); end
    check_log("inv", exp_inv[0], exp_inv[1], exp_inv[2], exp_inv[3]);
  endtask

  task automatic test_corrupt;
    bit seen, prev;
    clear_log();
    corrupt_en = 1;
    pulse_start(1'b0);
    wait_done(seen, prev);
    corrupt_en = 0;
    n_checks++; if (!seen || pass !== 1'b0) begin n_fail++; $display("FAIL corrupt_pass: got done=%b pass=%b want 1 0", seen, pass); end
    n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL corrupt_cnt: got %0d want 1", err_cnt); end
    n_checks++; if (first_err_addr !== 24'd2 || first_err_data !== 16'h0000) begin n_fail++; $display("FAIL corrupt_first: got addr=%h data=%h want 2 0000", first_err_addr, first_err_data); end
  endtask

  task automatic test_stall;
    bit seen;
    int unstable, stall_cycles;
    logic prev_req;
    logic [AW+DW:0] prev_f;
    clear_log();
    stall_en = 1; seen = 0; unstable = 0; stall_cycles = 0;
    pulse_start(1'b0);
    prev_req = 1'b0; prev_f = '0;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin seen = 1; break; end
      if (sdram_req && prev_req && {sdram_addr, sdram_rh_wl, sdram_data_w} != prev_f) unstable++;
      if (sdram_req && !sdram_rh_wl && sdram_addr == 24'd2) stall_cycles++;
      prev_req = sdram_req;
      prev_f   = {sdram_addr, sdram_rh_wl, sdram_data_w};
      @(negedge clk);
    end
    stall_en = 0;
    n_checks++; if (!seen || pass !== 1'b1) begin n_fail++; $display("FAIL stall_result: got done=%b pass=%b want 1 1", seen, pass); end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL stall_stable: got %0d field changes want 0", unstable); end
    n_checks++; if (stall_cycles < 11) begin n_fail++; $display("FAIL stall_len: got %0d req cycles at addr 2 want >=11", stall_cycles); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (wr_cnt[i] != 1) begin n_fail++; $display("FAIL stall_writes[%0d]: got %0d want 1", i, wr_cnt[i]); end
    end
  endtask

  task automatic test_start_busy;
    bit seen, prev;
    clear_log();
    pulse_start(1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; pat_inv = 1'b1;
    @(negedge clk);
    start = 1'b0; pat_inv = 1'b0;
    wait_done(seen, prev);
    n_checks++; if (!seen || pass !== 1'b1) begin n_fail++; $display("FAIL busy_start_result: got done=%b pass=%b want 1 1", seen, pass); end
    check_log("busy_start", exp_plain[0], exp_plain[1], exp_plain[2], exp_plain[3]);
  endtask

  task automatic test_reset_mid;
    bit found, seen, prev;
    found = 0;
    clear_log();
    pulse_start(1'b0);
    for (int c = 0; c < 200; c++) begin
      if (busy && sdram_rh_wl && !sdram_req) begin found = 1; break; end
      @(negedge clk);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL reset_mid_reach: got no RD_WAIT want RD_WAIT within 200 cycles"); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (sdram_req !== 1'b0 || busy !== 1'b0 || sdram_rh_wl !== 1'b0) begin n_fail++; $display("FAIL reset_mid_async: got req=%b busy=%b rw=%b want 0 0 0", sdram_req, busy, sdram_rh_wl); end
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    pulse_start(1'b0);
    wait_done(seen, prev);
    n_checks++; if (!seen || pass !== 1'b1) begin n_fail++; $display("FAIL reset_mid_rerun: got done=%b pass=%b want 1 1", seen, pass); end
    check_log("rerun", exp_plain[0], exp_plain[1], exp_plain[2], exp_plain[3]);
  endtask

  task automatic test_timeout;
`ifdef SDRAM_TEST_TIMEOUT_EN
    int cnt;
    bit seen;
    cnt = 0; seen = 0;
    never_ack = 1;
    pulse_start(1'b0);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      cnt++;
      if (done) begin seen = 1; break; end
    end
    never_ack = 0;
    n_checks++; if (!seen || cnt != 21) begin n_fail++; $display("FAIL timeout_latency: got done=%b after %0d cycles want 21", seen, cnt); end
    n_checks++; if (timeout !== 1'b1 || pass !== 1'b0 || sdram_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_flags: got tmo=%b pass=%b req=%b busy=%b want 1 0 0 0", timeout, pass, sdram_req, busy); end
    repeat (2) @(negedge clk);
`else
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_tied: got %b want 0", timeout); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pat_inv();
    test_corrupt();
    test_stall();
    test_start_busy();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_test_master.md
# sdram_test_master

Requester-side client for the SDRAM controller's request/acknowledge port. On `start`, it writes a deterministic pattern over a configurable address window, one word per transaction. It then reads the window back and compares each word, reporting pass/fail, a saturating error count and the first failing address. It sits between the board-level test sequencer and the controller, replacing user logic during memory bring-up.

## Interface
- `ADDR_WIDTH`, 24: client word-address width ({bank, row, col}).
- `DATA_WIDTH`, 16: data word width.
- `ADDR_FIRST`, 0: first address tested.
- `ADDR_LAST`, 1023: last address tested, inclusive; must be >= `ADDR_FIRST`.
- `SEED`, 16'hA5C3: XOR seed for the pattern.
- `TIMEOUT_CYCLES`, 2047: watchdog limit per transaction; used only with `SDRAM_TEST_TIMEOUT_EN`.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1: single clock, shared with the SDRAM controller.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse that starts a run; honoured only in IDLE.
- `pat_inv`  in  1: sampled with `start`; 1 inverts the pattern.
- `busy`  out  1: high from the cycle after `start` until DONE.
- `done`  out  1: one-cycle pulse at run end.
- `pass`  out  1: valid from `done` until the next `start`; 1 means `err_cnt`==0 and no timeout.
- `timeout`  out  1: sticky until the next `start`; set when the watchdog fires.
- `err_cnt`  out  16: mismatch count, saturating at 16'hFFFF.
- `first_err_addr`  out  ADDR_WIDTH: address of the first mismatch.
- `first_err_data`  out  DATA_WIDTH: data read at the first mismatch.
- `sdram_req`  out  1: request to the controller.
- `sdram_ack`  in  1: one-cycle acknowledge from the controller.
- `sdram_addr`  out  ADDR_WIDTH: request address.
- `sdram_rh_wl`  out  1: 1 = read, 0 = write.
- `sdram_data_w`  out  DATA_WIDTH: write data.
- `sdram_data_r`  in  DATA_WIDTH: read data.
- `sdram_data_r_en`  in  1: read-data-valid pulse.

## Operation
- Pattern: `pat(a) = a[DATA_WIDTH-1:0] ^ SEED`, bitwise inverted when the latched `pat_inv` is 1. Address bits above `DATA_WIDTH` are ignored.
- States and transitions:
  - IDLE -> WR_REQ on `start`. This clears `err_cnt`, `first_err_*`, `pass` and `timeout`, and loads `addr = ADDR_FIRST`.
  - WR_REQ: drive `req=1`, `rh_wl=0`, `addr`, `data_w=pat(addr)`. On `ack` -> WR_HOLD.
  - WR_HOLD: one cycle with `req=0`, request fields still held.
    - If `addr==ADDR_LAST`: reload `ADDR_FIRST` -> RD_REQ.
    - Else: `addr+1` -> WR_REQ.
  - RD_REQ: drive `req=1`, `rh_wl=1`. On `ack` -> RD_WAIT.
  - RD_WAIT: `req=0`, fields held. On `data_r_en`, compare `data_r` with `pat(addr)`.
    - Mismatch: increment `err_cnt` (saturating). If this is the first mismatch, latch `first_err_addr` and `first_err_data`.
    - Then advance as in WR_HOLD, but `addr==ADDR_LAST` -> DONE.
  - DONE: pulse `done`, set `pass`, -> IDLE.
- Handshake rules:
  - Exactly one outstanding transaction.
  - `addr`, `rh_wl` and `data_w` stay stable from `req` rise until the transaction retires: WR_HOLD exit for writes, `data_r_en` for reads.
  - `req` drops on the cycle after `ack` is sampled.
  - `ack` outside WR_REQ/RD_REQ is ignored.
  - `data_r_en` outside RD_WAIT is ignored.
- The controller's refresh stalls only delay `ack`; no special handling is required.
- `start` while busy is ignored.
- An `ack` and a `start` in the same cycle cannot conflict (`start` is only honoured in IDLE).

## Timing
- Reset values:
  - Control outputs: `req`, `rh_wl`, `busy`, `done`, `pass` and `timeout` are 0.
  - Data outputs: `err_cnt`, `first_err_*`, `sdram_addr` and `sdram_data_w` are 0.
  - State: IDLE.
- Reset mid-run: the block returns to IDLE immediately and `req` drops asynchronously. The controller is reset alongside it.
- `start` at edge N -> `busy`=1 and `req`=1 from N+1.
- All outputs are registered; no combinational paths from inputs to outputs.
- Minimum per-word loop is fixed by controller latency. The master adds one cycle per write (WR_HOLD) and zero per read beyond `data_r_en`.
- `done` is asserted one cycle after the last `data_r_en`; `busy` falls on that same cycle.

## Configuration
- Macro: `SDRAM_TEST_TIMEOUT_EN`.
- With the macro defined:
  - A per-transaction counter is cleared on entry to WR_REQ and RD_REQ.
  - It counts in WR_REQ, RD_REQ and RD_WAIT.
  - When it reaches `TIMEOUT_CYCLES` without the awaited `ack`/`data_r_en`: set `timeout`, drop `req`, -> DONE with `pass=0`.
- Without the macro: no counter, `timeout` is tied to 0, and the block waits indefinitely.

## Test plan
- Ideal memory model, `ADDR_FIRST=0`, `ADDR_LAST=3`, `SEED=16'hA5C3`, `pat_inv=0`:
  - Writes 16'hA5C3, A5C2, A5C1, A5C0 to addresses 0..3.
  - `done` pulses; `pass=1`, `err_cnt=0`.
- Same setup, `pat_inv=1`: write data is 16'h5A3C, 5A3D, 5A3E, 5A3F; `pass=1`.
- Model corrupts the read at address 2 (returns 16'h0000): `err_cnt=1`, `first_err_addr=2`, `first_err_data=16'h0000`, `pass=0`.
- Model delays `ack` by a 10-cycle refresh stall mid-write: request fields stay stable throughout; exactly one write per address; `pass=1`.
- `start` pulsed while busy: no effect. Assert `reset` during RD_WAIT: `req=0` and IDLE within the same cycle; a new `start` then completes with `pass=1`.
- Timeout: with `SDRAM_TEST_TIMEOUT_EN` and `TIMEOUT_CYCLES=20`, model never acks. `timeout=1`, `done` pulses 21 cycles after `req` rise, `pass=0`.
